// File: rtl/mrd_pkg.sv
// Shared types and constants for the mixed-radix DFT stage sequencer.
package mrd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned NLANE     = 5;
  localparam logic [2:0]  RADIX_MIN = 3'd2;
  localparam logic [2:0]  RADIX_MAX = 3'd5;
  localparam int unsigned ADDR_W    = 11;

  typedef logic [NLANE-1:0][ADDR_W-1:0] addr5_t;

  function automatic logic radix_ok_f(input logic [2:0] radix);
    return (radix >= RADIX_MIN) && (radix <= RADIX_MAX);
  endfunction

  function automatic logic [NLANE-1:0] lane_mask_f(input logic [2:0] radix);
    case (radix)
      3'd2:    return 5'b00011;
      3'd3:    return 5'b00111;
      3'd4:    return 5'b01111;
      3'd5:    return 5'b11111;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mrd_dly_line.sv
// Valid + payload shift register; exposes every stage valid bit so callers can tap or drain-check.
module mrd_dly_line #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_val_i,
  input  logic [W-1:0]     in_data_i,
  output logic [DEPTH-1:0] vld_o,
  output logic [W-1:0]     out_data_o
);

  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] dat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= in_val_i;
      dat_q[0] <= in_data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o      = vld_q;
  assign out_data_o = dat_q[DEPTH-1];

endmodule

// File: rtl/mrd_rdx_ctrl.sv
// Mixed-radix DFT stage sequencer: issues per-lane read addresses and delayed write-back.
// Optional twiddle-index generation is enabled with `define MRD_CTRL_TWID_EN.
module mrd_rdx_ctrl
  import mrd_pkg::*;
#(
  parameter int unsigned wAddr   = 11,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned ENG_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2:0]                    cfg_radix,
  input  logic [wAddr-1:0]              cfg_ngroups,
  input  logic [wAddr-1:0]              cfg_stride,
`ifdef MRD_CTRL_TWID_EN
  input  logic [wAddr-1:0]              cfg_n,
  output logic [NLANE-1:0][wAddr-1:0]   tw_idx,
`endif
  input  logic                          stall,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic                          rd_en,
  output logic [NLANE-1:0][wAddr-1:0]   rd_addr,
  output logic [NLANE-1:0]              lane_mask,
  output logic                          eng_in_val,
  output logic                          wr_en,
  output logic [NLANE-1:0][wAddr-1:0]   wr_addr
);

  localparam int unsigned WR_LAT = RD_LAT + ENG_LAT;

  state_t                      state_q, state_d;
  logic [wAddr-1:0]            ngrp_q;
  logic [wAddr-1:0]            g_q;
  logic [NLANE-1:0][wAddr-1:0] addr_q;
  logic [NLANE-1:0][wAddr-1:0] lane_off;
  logic [NLANE-1:0]            mask_q;
  logic                        cfg_err_q;
  logic                        accept, reject, pend;
  logic [WR_LAT-1:0]           wr_vld;

  assign accept = (state_q == IDLE) && start &&  radix_ok_f(cfg_radix);
  assign reject = (state_q == IDLE) && start && !radix_ok_f(cfg_radix);

  // Lane k start offset k*stride from shifts and one add.
  always_comb begin
    lane_off    = '0;
    lane_off[1] = cfg_stride;
    lane_off[2] = cfg_stride << 1;
    lane_off[3] = (cfg_stride << 1) + cfg_stride;
    lane_off[4] = cfg_stride << 2;
  end

  // Drain ends when the only remaining entry is the one writing back this cycle,
  // so DONE lands on the cycle right after the last write.
  assign pend = |wr_vld[WR_LAT-2:0];

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (cfg_ngroups == '0) ? DRAIN : ISSUE;
      end
      ISSUE: begin
        if (!stall) begin
          rd_en = 1'b1;
          if (g_q == ngrp_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ngrp_q    <= '0;
      g_q       <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= reject;
      if (accept) begin
        ngrp_q <= cfg_ngroups;
        g_q    <= '0;
        addr_q <= lane_off;
        mask_q <= lane_mask_f(cfg_radix);
      end else if (rd_en) begin
        g_q <= g_q + 1'b1;
        for (int unsigned k = 0; k < NLANE; k++) addr_q[k] <= addr_q[k] + 1'b1;
      end
    end
  end

  mrd_dly_line #(
    .DEPTH (WR_LAT),
    .W     (NLANE*wAddr)
  ) u_wr_dly (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_val_i   (rd_en),
    .in_data_i  (addr_q),
    .vld_o      (wr_vld),
    .out_data_o (wr_addr)
  );

`ifdef MRD_CTRL_TWID_EN
  logic [wAddr-1:0]            cfg_n_q;
  logic [NLANE-1:0][wAddr-1:0] tw_q, tw_d;
  logic [NLANE-1:0][wAddr:0]   tw_sum;
  logic [RD_LAT-1:0]           tw_vld;

  // Per-lane modular accumulator: tw[k] steps by k and wraps by one subtraction.
  always_comb begin
    tw_d   = tw_q;
    tw_sum = '0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      tw_sum[k] = {1'b0, tw_q[k]} + (wAddr+1)'(k);
      if (tw_sum[k] >= {1'b0, cfg_n_q}) tw_sum[k] = tw_sum[k] - {1'b0, cfg_n_q};
      tw_d[k] = tw_sum[k][wAddr-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_n_q <= '0;
      tw_q    <= '0;
    end else if (accept) begin
      cfg_n_q <= cfg_n;
      tw_q    <= '0;
    end else if (rd_en) begin
      tw_q <= tw_d;
    end
  end

  mrd_dly_line #(
    .DEPTH (RD_LAT),
    .W     (NLANE*wAddr)
  ) u_tw_dly (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_val_i   (rd_en),
    .in_data_i  (tw_q),
    .vld_o      (tw_vld),
    .out_data_o (tw_idx)
  );

  assign eng_in_val = tw_vld[RD_LAT-1];
`else
  assign eng_in_val = wr_vld[RD_LAT-1];
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;
  assign rd_addr   = addr_q;
  assign lane_mask = mask_q;
  assign wr_en     = wr_vld[WR_LAT-1];

endmodule

// File: tb/tb_mrd_rdx_ctrl.sv
// Scoreboard bench for mrd_rdx_ctrl: expected read/engine/write/done events queued per run.
module tb_mrd_rdx_ctrl;
  import mrd_pkg::*;

  typedef struct {
    int         cyc;
    addr5_t     a;
    addr5_t     t;
    logic [4:0] m;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cfg_radix = '0;
  logic [10:0] cfg_ngroups = '0;
  logic [10:0] cfg_stride = '0;
  logic [10:0] cfg_n = 11'd10;
  logic        stall = 1'b0;
  logic        busy, done, cfg_err, rd_en, eng_in_val, wr_en;
  logic [4:0]  lane_mask;
  addr5_t      rd_addr, wr_addr;
`ifdef MRD_CTRL_TWID_EN
  addr5_t      tw_idx;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int b_lo  = 1;
  int b_hi  = 0;

  ev_t rdq[$], engq[$], wrq[$];
  int  doneq[$], errq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mrd_rdx_ctrl #(.wAddr(11), .RD_LAT(1), .ENG_LAT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_radix   (cfg_radix),
    .cfg_ngroups (cfg_ngroups),
    .cfg_stride  (cfg_stride),
`ifdef MRD_CTRL_TWID_EN
    .cfg_n       (cfg_n),
    .tw_idx      (tw_idx),
`endif
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .lane_mask   (lane_mask),
    .eng_in_val  (eng_in_val),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic zero_chk(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_mask"}, lane_mask, 0);
    check({tag, "_eng_val"}, eng_in_val, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
`ifdef MRD_CTRL_TWID_EN
    check({tag, "_tw"}, tw_idx, 0);
`endif
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst) begin
      check("busy", busy, (cyc >= b_lo && cyc <= b_hi));
      if (rd_en) begin
        if (rdq.size() == 0) check("rd_unexp", 1, 0);
        else begin
          e = rdq.pop_front();
          check("rd_cyc", cyc, e.cyc);
          check("rd_mask", lane_mask, e.m);
          for (int k = 0; k < 5; k++) if (e.m[k]) check("rd_addr", rd_addr[k], e.a[k]);
        end
      end
      if (eng_in_val) begin
        if (engq.size() == 0) check("eng_unexp", 1, 0);
        else begin
          e = engq.pop_front();
          check("eng_cyc", cyc, e.cyc);
`ifdef MRD_CTRL_TWID_EN
          for (int k = 0; k < 5; k++) if (e.m[k]) check("tw_idx", tw_idx[k], e.t[k]);
`endif
        end
      end
      if (wr_en) begin
        if (wrq.size() == 0) check("wr_unexp", 1, 0);
        else begin
          e = wrq.pop_front();
          check("wr_cyc", cyc, e.cyc);
          for (int k = 0; k < 5; k++) if (e.m[k]) check("wr_addr", wr_addr[k], e.a[k]);
        end
      end
      if (done) begin
        if (doneq.size() == 0) check("done_unexp", 1, 0);
        else check("done_cyc", cyc, doneq.pop_front());
      end
      if (cfg_err) begin
        if (errq.size() == 0) check("err_unexp", 1, 0);
        else check("err_cyc", cyc, errq.pop_front());
      end
    end
  end

  // One stage run: st2 = cycle of an extra (to be ignored) start, rst_at = cycle to pulse reset.
  task automatic run(input logic [2:0] r, input int ng, input int st, input int n,
                     input logic [31:0] stl, input int st2, input int rst_at);
    int s, rel, g, last, done_rel, end_rel;
    bit ok;
    ev_t e;
    logic [4:0] m;
    @(posedge clk); #1;
    s           = cyc;
    cfg_radix   = r;
    cfg_ngroups = 11'(ng);
    cfg_stride  = 11'(st);
    cfg_n       = 11'(n);
    start       = 1'b1;
    stall       = stl[0];
    ok          = (r >= 3'd2 && r <= 3'd5);
    m           = ok ? 5'((1 << r) - 1) : 5'b0;
    if (ok) begin
      rel = 1; g = 0; last = 0;
      while (g < ng) begin
        if (rel < 32 && stl[rel]) rel++;
        else begin
          e.m = m;
          for (int k = 0; k < 5; k++) begin
            e.a[k] = 11'((g + k*st) % 2048);
            e.t[k] = 11'((g*k) % n);
          end
          e.cyc = s + rel;     rdq.push_back(e);
          e.cyc = s + rel + 1; engq.push_back(e);
          e.cyc = s + rel + 4; wrq.push_back(e);
          last = rel; g++; rel++;
        end
      end
      done_rel = (ng == 0) ? 2 : last + 5;
      doneq.push_back(s + done_rel);
      b_lo = s + 1;
      b_hi = s + done_rel;
      end_rel = done_rel + 2;
    end else begin
      errq.push_back(s + 1);
      end_rel = 3;
    end
    for (rel = 1; rel <= end_rel; rel++) begin
      @(posedge clk); #1;
      start = (rel == st2);
      if (rel == st2) begin
        cfg_radix = 3'd2; cfg_ngroups = 11'd7; cfg_stride = 11'd1;
      end else begin
        cfg_radix = r; cfg_ngroups = 11'(ng); cfg_stride = 11'(st);
      end
      stall = (rel < 32) ? stl[rel] : 1'b0;
      if (rst_at != 0 && rel == rst_at) rst = 1'b1;
      if (rst_at != 0 && rel == rst_at + 1) begin
        rst = 1'b0;
        rdq.delete(); engq.delete(); wrq.delete(); doneq.delete(); errq.delete();
        b_lo = 1; b_hi = 0;
        @(negedge clk);
        zero_chk("rst_mid");
      end
    end
    check("rdq_left", rdq.size(), 0);
    check("engq_left", engq.size(), 0);
    check("wrq_left", wrq.size(), 0);
    check("doneq_left", doneq.size(), 0);
    check("errq_left", errq.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    zero_chk("reset");

    run(3'd3, 4, 4, 10, 32'h0, 0, 0);          // baseline
    run(3'd3, 4, 4, 10, 32'h4, 0, 0);          // stall in cycle 2
    run(3'd6, 4, 4, 10, 32'h0, 0, 0);          // illegal radix
    run(3'd1, 4, 4, 10, 32'h0, 0, 0);          // illegal radix below range
    run(3'd5, 0, 4, 10, 32'h0, 0, 0);          // zero groups
    run(3'd3, 4, 4, 10, 32'h0, 2, 0);          // start while busy ignored
    run(3'd3, 4, 4, 10, 32'h0, 0, 7);          // reset during drain
    run(3'd3, 4, 4, 10, 32'h0, 0, 0);          // fresh start after reset
    run(3'd4, 3, 1000, 10, 32'h0, 0, 0);       // address wrap mod 2^11
    run(3'd2, 5, 7, 10, 32'h1A, 0, 0);         // scattered stalls
    run(3'd5, 2, 1, 10, 32'h0, 0, 0);          // twiddle indices with cfg_n=10
    run(3'd5, 6, 3, 4, 32'h0, 0, 0);           // twiddle wrap with small cfg_n

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
